// File: rtl/systolic_ctrl_if.sv
// Command/status bundle between a job issuer and the systolic array controller.
// The issuer (master) drives start/tiles/abort; the controller (slave) drives the rest.
interface systolic_ctrl_if #(
   parameter int K    = 4,
   parameter int COLS = 2
);
   localparam int AW = (K > 1) ? $clog2(K) : 1;
   localparam int OW = (COLS > 1) ? $clog2(COLS) : 1;

   logic          start;
   logic [7:0]    tiles;
   logic          abort;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic          rst_accumulator;
   logic          stream_out_rdy;
   logic          out_valid;
   logic [OW-1:0] out_idx;
   logic [7:0]    tile_idx;
   logic          busy;
   logic          done;

   modport master (
      output start, tiles, abort,
      input  rd_en, rd_addr, rst_accumulator, stream_out_rdy,
      input  out_valid, out_idx, tile_idx, busy, done
   );

   modport slave (
      input  start, tiles, abort,
      output rd_en, rd_addr, rst_accumulator, stream_out_rdy,
      output out_valid, out_idx, tile_idx, busy, done
   );
endinterface

// File: rtl/systolic_ctrl.sv
// Sequencer for a ROWS x COLS output-stationary MAC array: per tile it feeds K operand
// beats, waits for the pipeline to drain, then streams COLS result beats.
module systolic_ctrl #(
   parameter int ROWS     = 2,
   parameter int COLS     = 2,
   parameter int K        = 4,
   parameter int MULT_LAT = 3,
   parameter int ADD_LAT  = 1
) (
   input  logic                clk,
   input  logic                rst,
   systolic_ctrl_if.slave      bus
);
   localparam int D    = MULT_LAT + ADD_LAT + ROWS + COLS;
   localparam int MAXV = (K > D) ? ((K > COLS) ? K : COLS) : ((D > COLS) ? D : COLS);
   localparam int CW   = $clog2(MAXV) + 1;
   localparam int AW   = (K > 1) ? $clog2(K) : 1;
   localparam int OW   = (COLS > 1) ? $clog2(COLS) : 1;

   localparam logic [CW-1:0] K_LAST = CW'(K - 1);
   localparam logic [CW-1:0] D_LAST = CW'(D - 1);
   localparam logic [CW-1:0] C_LAST = CW'(COLS - 1);

   typedef enum logic [2:0] {S_IDLE, S_FEED, S_DRAIN, S_STREAM, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    tile_q, tile_d;
   logic [7:0]    tiles_q, tiles_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         tile_q  <= '0;
         tiles_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tile_q  <= tile_d;
         tiles_q <= tiles_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      tile_d  = tile_q;
      tiles_d = tiles_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (bus.start) begin
               state_d = S_FEED;
               tile_d  = '0;
               tiles_d = (bus.tiles == 8'd0) ? 8'd1 : bus.tiles;
            end
         end
         S_FEED: begin
            if (cnt_q == K_LAST) begin
               state_d = S_DRAIN;
               cnt_d   = '0;
            end
         end
         S_DRAIN: begin
            if (cnt_q == D_LAST) begin
               state_d = S_STREAM;
               cnt_d   = '0;
            end
         end
         S_STREAM: begin
            if (cnt_q == C_LAST) begin
               cnt_d = '0;
               if (tile_q < tiles_q - 8'd1) begin
                  state_d = S_FEED;
                  tile_d  = tile_q + 8'd1;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            tile_d  = '0;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            tile_d  = '0;
         end
      endcase
      // Abort outranks every transition, including a start seen in IDLE.
      if (bus.abort) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         tile_d  = '0;
      end
   end

   assign bus.rd_en           = (state_q == S_FEED);
   assign bus.rd_addr         = (state_q == S_FEED) ? cnt_q[AW-1:0] : '0;
   assign bus.rst_accumulator = (state_q == S_FEED) && (cnt_q == '0);
   assign bus.stream_out_rdy  = (state_q == S_STREAM) && (cnt_q == '0);
   assign bus.out_valid       = (state_q == S_STREAM);
   assign bus.out_idx         = (state_q == S_STREAM) ? cnt_q[OW-1:0] : '0;
   assign bus.tile_idx        = tile_q;
   assign bus.busy            = (state_q != S_IDLE);
   assign bus.done            = (state_q == S_DONE);
endmodule

// File: tb/tb_systolic_ctrl.sv
// Cycle-accurate directed checks of systolic_ctrl in its default configuration (D=8).
module tb_systolic_ctrl;
   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   systolic_ctrl_if #(.K(4), .COLS(2)) bus ();

   systolic_ctrl #(
      .ROWS(2), .COLS(2), .K(4), .MULT_LAT(3), .ADD_LAT(1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       rd_en;
      logic [1:0] rd_addr;
      logic       racc;
      logic       sor;
      logic       ov;
      logic       oidx;
      logic [7:0] tidx;
      logic       busy;
      logic       done;
   } outs_t;

   typedef struct {
      bit start; int tiles; bit abort;
      int rd_en; int rd_addr; int racc; int sor; int ov; int oidx; int tidx; int busy; int done;
   } vec_t;

   vec_t tbl [17];

   // Expected outputs in job-relative cycle c (start sampled at the end of cycle 0);
   // every tile pass is 4 feed + 8 drain + 2 stream = 14 cycles.
   function automatic outs_t model(int c, int nt);
      outs_t o;
      int p, r;
      o = '0;
      if (c >= 1 && c <= 14 * nt) begin
         p = (c - 1) / 14;
         r = (c - 1) % 14;
         o.busy = 1'b1;
         o.tidx = 8'(p);
         if (r < 4) begin
            o.rd_en   = 1'b1;
            o.rd_addr = 2'(r);
            o.racc    = (r == 0);
         end else if (r >= 12) begin
            o.ov   = 1'b1;
            o.oidx = 1'(r - 12);
            o.sor  = (r == 12);
         end
      end else if (c == 14 * nt + 1) begin
         o.busy = 1'b1;
         o.done = 1'b1;
         o.tidx = 8'(nt - 1);
      end
      return o;
   endfunction

   function automatic outs_t from_vec(vec_t v);
      outs_t o;
      o.rd_en   = 1'(v.rd_en);
      o.rd_addr = 2'(v.rd_addr);
      o.racc    = 1'(v.racc);
      o.sor     = 1'(v.sor);
      o.ov      = 1'(v.ov);
      o.oidx    = 1'(v.oidx);
      o.tidx    = 8'(v.tidx);
      o.busy    = 1'(v.busy);
      o.done    = 1'(v.done);
      return o;
   endfunction

   task automatic check(string nm, int c, outs_t exp);
      outs_t act;
      act = {bus.rd_en, bus.rd_addr, bus.rst_accumulator, bus.stream_out_rdy,
             bus.out_valid, bus.out_idx, bus.tile_idx, bus.busy, bus.done};
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s c=%0d got=%05h want=%05h", nm, c, act, exp);
      end
   endtask

   // Drive one cycle's inputs, check that cycle's outputs, move to the next cycle.
   task automatic apply(string nm, int c, bit st, int tl, bit ab, outs_t exp);
      bus.start = st;
      bus.tiles = 8'(tl);
      bus.abort = ab;
      check(nm, c, exp);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.start = 1'b0;
      bus.abort = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.tiles = 8'd0;
      bus.abort = 1'b0;

      tbl[0]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      tbl[1]  = '{0, 5, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0};
      tbl[2]  = '{0, 5, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0};
      tbl[3]  = '{0, 5, 0, 1, 2, 0, 0, 0, 0, 0, 1, 0};
      tbl[4]  = '{0, 5, 0, 1, 3, 0, 0, 0, 0, 0, 1, 0};
      for (int i = 5; i <= 12; i++) tbl[i] = '{0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
      tbl[13] = '{0, 5, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0};
      tbl[14] = '{0, 5, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0};
      tbl[15] = '{0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
      tbl[16] = '{0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

      repeat (3) @(posedge clk);
      #1;
      check("reset_held", 0, '0);
      rst = 1'b0;
      apply("reset_release_idle", 0, 1'b0, 1, 1'b0, '0);
      check("idle_no_start", 1, '0);
      $display("job reset: checked");

      for (int i = 0; i < 17; i++)
         apply("base_tbl", i, tbl[i].start, tbl[i].tiles, tbl[i].abort, from_vec(tbl[i]));
      $display("job base tiles=1 (tiles input changed after start)");

      do_reset();
      for (int c = 0; c <= 44; c++)
         apply("tiles3", c, c == 0, 3, 1'b0, model(c, 3));
      $display("job tiles=3");

      do_reset();
      for (int c = 0; c <= 16; c++)
         apply("tiles0", c, c == 0, 0, 1'b0, model(c, 1));
      $display("job tiles=0");

      do_reset();
      for (int c = 0; c <= 25; c++)
         apply("abort", c, (c == 0) || (c == 9), 1, c == 7,
               (c <= 7) ? model(c, 1) : (c == 8) ? outs_t'('0) : model(c - 9, 1));
      $display("job abort in DRAIN then restart");

      do_reset();
      apply("start_abort_idle", 0, 1'b1, 1, 1'b1, '0);
      check("start_abort_idle_after", 1, '0);
      $display("job start+abort in IDLE");

      do_reset();
      for (int c = 0; c <= 12; c++)
         apply("rst_mid", c, 1'b1, 1, 1'b0, model(c, 1));
      bus.start = 1'b1;
      check("rst_mid", 13, model(13, 1));
      #2;
      rst = 1'b1;
      #1;
      check("rst_async_now", 13, '0);
      @(posedge clk);
      #1;
      check("rst_held_start", 14, '0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_released", 15, '0);
      @(posedge clk);
      #1;
      for (int c = 16; c <= 31; c++)
         apply("rst_restart", c, 1'b1, 1, 1'b0, model(c - 15, 1));
      $display("job rst mid-STREAM");

      do_reset();
      for (int c = 0; c <= 32; c++)
         apply("start_held", c, 1'b1, 1, 1'b0, (c <= 16) ? model(c, 1) : model(c - 16, 1));
      $display("job start held high");

      bus.start = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 SHALL have parameter ROWS, default 2: MAC array rows.
REQ-002 SHALL have parameter COLS, default 2: MAC array columns, and the number of output beats per tile.
REQ-003 SHALL have parameter K, default 4: inner dimension, and the number of operand feed cycles per tile.
REQ-004 SHALL have parameter MULT_LAT, default 3: MAC multiplier latency.
REQ-005 SHALL have parameter ADD_LAT, default 1: MAC adder latency.
REQ-006 SHALL have port clk, input, 1 bit: single clock, all state on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port start, input, 1 bit: begin a job; sampled only in IDLE.
REQ-009 SHALL have port tiles, input, 8 bits: tiles per job, latched on an accepted start; 0 is treated as 1.
REQ-010 SHALL have port abort, input, 1 bit: synchronous cancel of the current job.
REQ-011 SHALL have port rd_en, output, 1 bit: operand buffer read enable for the array edge.
REQ-012 SHALL have port rd_addr, output, $clog2(K) bits: k index into the operand buffers.
REQ-013 SHALL have port rst_accumulator, output, 1 bit: drives rst_accumulator_in of MAC[0][0].
REQ-014 SHALL have port stream_out_rdy, output, 1 bit: drives stream_out_rdy_in of MAC[0][0].
REQ-015 SHALL have port out_valid, output, 1 bit: psum_out beat valid at the array edge.
REQ-016 SHALL have port out_idx, output, $clog2(COLS) bits: index of the current output beat.
REQ-017 SHALL have port tile_idx, output, 8 bits: index of the current tile.
REQ-018 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-019 SHALL have port done, output, 1 bit: one-cycle pulse at job completion.

Function
REQ-020 SHALL implement an FSM with states IDLE, FEED, DRAIN, STREAM and DONE, all outputs decoded from registered state and counters.
REQ-021 SHALL move IDLE->FEED on the edge where start=1; start is ignored in every other state.
REQ-022 SHALL, in FEED:
- hold the state for exactly K cycles;
- drive rd_en=1 with rd_addr=0..K-1;
- drive rst_accumulator=1 only on the rd_addr=0 cycle;
- then go to DRAIN.
REQ-023 SHALL hold DRAIN for D = MULT_LAT+ADD_LAT+ROWS+COLS cycles, with rd_en=0, then go to STREAM.
REQ-024 SHALL, in STREAM:
- hold the state for exactly COLS cycles;
- drive stream_out_rdy=1 on the first cycle only;
- drive out_valid=1 with out_idx=0..COLS-1.
REQ-025 SHALL, at the end of STREAM, go to FEED and increment tile_idx if tile_idx < tiles_latched-1; otherwise go to DONE.
REQ-026 SHALL assert done=1 for exactly one cycle in DONE, then return to IDLE; a start in that DONE cycle is ignored.
REQ-027 SHALL size its counters to $clog2(max(K,D,COLS))+1 bits, with no wrap inside a phase; each phase counter clears to 0 on every state transition.
REQ-028 SHALL give abort=1 priority over all transitions: next state is IDLE, all outputs 0, no done pulse, tile_idx cleared.
REQ-029 SHALL keep the idle value (all outputs 0) when start and abort are both 1 in IDLE.
REQ-030 SHALL ignore changes to tiles after start is accepted.

Reset
REQ-031 SHALL, while rst=1 (asynchronously, at any point including mid-job), force state to IDLE, clear all counters and tiles_latched, and drive every output to 0.
REQ-032 SHALL leave IDLE on the first clk edge after rst falls only if start=1 on that edge.

Verification
REQ-033 SHALL cover the base job (ROWS=COLS=2, K=4, MULT_LAT=3, ADD_LAT=1, so D=8) with start at cycle 0 and tiles=1:
- rd_en high in cycles 1-4, rd_addr 0,1,2,3;
- rst_accumulator high in cycle 1 only;
- stream_out_rdy high in cycle 13;
- out_valid high in cycles 13-14, out_idx 0,1;
- done high in cycle 15 only;
- busy high in cycles 1-15.
REQ-034 SHALL cover tiles=3 with the same config: three FEED/DRAIN/STREAM passes of 14 cycles each, tile_idx 0,1,2, a single done pulse in cycle 43.
REQ-035 SHALL cover tiles=0: behaviour identical to tiles=1.
REQ-036 SHALL cover abort in cycle 7 (in DRAIN): busy=0 from cycle 8, no done, no stream_out_rdy; a new start in cycle 9 gives rd_en in cycle 10.
REQ-037 SHALL cover rst asserted mid-STREAM (cycle 13) between clock edges: all outputs 0 immediately, with no clk edge required; start held high throughout is ignored until rst is released.
REQ-038 SHALL cover start held high continuously: done in cycle 15, idle in cycle 16, second job rd_en from cycle 17.
